// File: rtl/banco_registros_param.sv
// Parametrised register bank: two combinational read ports, one write port with
// load/increment/decrement modes, multi-cycle sweep clear and registered zero flag.
// Optional write-to-read forwarding is enabled by defining BANCO_FWD_EN.
module banco_registros_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Clr,
  input  logic [ADDR_W-1:0] SelX,
  input  logic [ADDR_W-1:0] SelY,
  input  logic [ADDR_W-1:0] SelW,
  input  logic              RW,
  input  logic [1:0]        WMode,
  input  logic [DATA_W-1:0] DW,
  output logic [DATA_W-1:0] Rx,
  output logic [DATA_W-1:0] Ry,
  output logic              Busy,
  output logic              Zw
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              zw_q, zw_d;

  logic              wr_commit;
  logic [DATA_W-1:0] wr_res;

  // Clr takes priority over a simultaneous write, so the write never commits.
  always_comb begin
    wr_res = DW;
    case (WMode)
      2'b01:   wr_res = regs_q[SelW] + DATA_W'(1);
      2'b10:   wr_res = regs_q[SelW] - DATA_W'(1);
      default: wr_res = DW;
    endcase
    wr_commit = (state_q == StIdle) && RW && (WMode != 2'b11) && !Clr;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    zw_d    = zw_q;
    case (state_q)
      StIdle: begin
        if (Clr) begin
          regs_d[0] = '0;
          cnt_d     = ADDR_W'(1);
          state_d   = StClear;
        end else if (wr_commit) begin
          regs_d[SelW] = wr_res;
          zw_d         = (wr_res == '0);
        end
      end
      StClear: begin
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(NREG - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      zw_q    <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zw_q    <= zw_d;
      regs_q  <= regs_d;
    end
  end

  always_comb begin
    Rx = regs_q[SelX];
    Ry = regs_q[SelY];
`ifdef BANCO_FWD_EN
    if (wr_commit && (SelX == SelW)) Rx = wr_res;
    if (wr_commit && (SelY == SelW)) Ry = wr_res;
`endif
  end

  assign Busy = (state_q == StClear);
  assign Zw   = zw_q;

endmodule

// File: tb/tb_banco_registros_param.sv
// Randomised and directed bench for banco_registros_param against an array-based
// reference model of the register bank; honours BANCO_FWD_EN for read expectations.
module tb_banco_registros_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  logic              Clk = 1'b0;
  logic              Rst, Clr, RW;
  logic [ADDR_W-1:0] SelX, SelY, SelW;
  logic [1:0]        WMode;
  logic [DATA_W-1:0] DW;
  logic [DATA_W-1:0] Rx, Ry;
  logic              Busy, Zw;

  banco_registros_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Clr   (Clr),
    .SelX  (SelX),
    .SelY  (SelY),
    .SelW  (SelW),
    .RW    (RW),
    .WMode (WMode),
    .DW    (DW),
    .Rx    (Rx),
    .Ry    (Ry),
    .Busy  (Busy),
    .Zw    (Zw)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register contents, zero flag, and the next register a
  // sweep will clear (0 means no sweep in progress).
  int ref_reg [NREG];
  int ref_zw;
  int sweep_idx;

`ifdef BANCO_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int write_result(input int mode, input int sel, input int data);
    case (mode)
      1:       return (ref_reg[sel] + 1) % 256;
      2:       return (ref_reg[sel] + 255) % 256;
      default: return data;
    endcase
  endfunction

  function automatic bit committing(input bit clr, input bit rw, input int mode);
    return (sweep_idx == 0) && rw && (mode != 3) && !clr;
  endfunction

  function automatic int exp_read(input int sel, input bit clr, input bit rw, input int mode,
                                  input int selw, input int data);
    if (Fwd && committing(clr, rw, mode) && sel == selw) return write_result(mode, selw, data);
    return ref_reg[sel];
  endfunction

  // One clock: drive inputs, check combinational/held outputs before the edge,
  // clock, then advance the model.
  task automatic step(input bit rst, input bit clr, input bit rw, input int mode,
                      input int selx, input int sely, input int selw, input int data,
                      input bit do_check);
    int res;
    Rst = rst; Clr = clr; RW = rw; WMode = mode[1:0];
    SelX = selx[ADDR_W-1:0]; SelY = sely[ADDR_W-1:0]; SelW = selw[ADDR_W-1:0];
    DW = data[DATA_W-1:0];
    #1;
    if (do_check) begin
      check_val("rx", int'(Rx), exp_read(selx, clr, rw, mode, selw, data));
      check_val("ry", int'(Ry), exp_read(sely, clr, rw, mode, selw, data));
      check_val("busy", int'(Busy), int'(sweep_idx != 0));
      check_val("zw", int'(Zw), ref_zw);
    end
    @(posedge Clk);
    if (rst) begin
      foreach (ref_reg[i]) ref_reg[i] = 0;
      ref_zw = 0;
      sweep_idx = 0;
    end else if (sweep_idx != 0) begin
      ref_reg[sweep_idx] = 0;
      sweep_idx = (sweep_idx + 1 == NREG) ? 0 : sweep_idx + 1;
    end else if (clr) begin
      ref_reg[0] = 0;
      sweep_idx = 1;
    end else if (committing(clr, rw, mode)) begin
      res = write_result(mode, selw, data);
      ref_reg[selw] = res;
      ref_zw = int'(res == 0);
    end
    @(negedge Clk);
  endtask

  task automatic idle_read(input int selx, input int sely);
    step(1'b0, 1'b0, 1'b0, 0, selx, sely, 0, 0, 1'b1);
  endtask

  initial begin
    int mode, data;
    bit rst, clr, rw;

    foreach (ref_reg[i]) ref_reg[i] = 0;
    ref_zw = 0;
    sweep_idx = 0;
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    check_val("reset_busy", int'(Busy), 0);
    check_val("reset_zw", int'(Zw), 0);

    // Load 0x0A+i everywhere, then read forwards on X and backwards on Y.
    for (int i = 0; i < NREG; i++) step(1'b0, 1'b0, 1'b1, 0, i, 7 - i, i, 'h0A + i, 1'b1);
    for (int i = 0; i < NREG; i++) begin
      #1;
      SelX = i[ADDR_W-1:0]; SelY = 3'(7 - i); RW = 1'b0;
      #1;
      check_val("t1_rx", int'(Rx), 'h0A + i);
      check_val("t1_ry", int'(Ry), 'h0A + 7 - i);
      idle_read(i, 7 - i);
    end
    check_val("t1_zw", int'(Zw), 0);

    // Increment wraps to zero, decrement wraps back to all-ones.
    step(1'b0, 1'b0, 1'b1, 0, 3, 3, 3, 'hFF, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1, 3, 3, 3, 'h12, 1'b1);
    check_val("t2_zw_set", int'(Zw), 1);
    idle_read(3, 0);
    step(1'b0, 1'b0, 1'b1, 2, 3, 3, 3, 'h00, 1'b1);
    check_val("t2_zw_clr", int'(Zw), 0);
    idle_read(3, 3);

    // Clr together with a write: the write is dropped, sweep takes NREG edges.
    step(1'b0, 1'b1, 1'b1, 0, 2, 0, 2, 'h55, 1'b1);
    for (int i = 0; i < NREG - 1; i++) begin
      check_val("t3_busy", int'(Busy), 1);
      step(1'b0, 1'b0, 1'b1, 0, i, 2, i, 'h77, 1'b1);
    end
    check_val("t3_busy_done", int'(Busy), 0);
    for (int i = 0; i < NREG; i++) idle_read(i, 7 - i);

    // Reset aborts a sweep on its 4th edge; the next Clr runs a full sweep.
    for (int i = 0; i < NREG; i++) step(1'b0, 1'b0, 1'b1, 0, i, i, i, 'h40 + i, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 5, 6, 0, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 1, 2, 0, 0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 3, 4, 0, 0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 5, 6, 0, 0, 1'b1);
    check_val("t4_busy", int'(Busy), 0);
    check_val("t4_zw", int'(Zw), 0);
    for (int i = 0; i < NREG; i++) idle_read(i, 7 - i);
    step(1'b0, 1'b0, 1'b1, 0, 6, 6, 6, 'h21, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 6, 6, 0, 0, 1'b1);
    for (int i = 0; i < NREG - 1; i++) step(1'b0, 1'b0, 1'b0, 0, 6, i, 0, 0, 1'b1);
    check_val("t4_sweep_done", int'(Busy), 0);

    // Same-address read during a write: forwarding depends on the build.
    step(1'b0, 1'b0, 1'b1, 0, 5, 5, 5, 'h11, 1'b1);
    SelX = 3'd5; SelY = 3'd5; SelW = 3'd5; RW = 1'b1; WMode = 2'b00; DW = 8'h3C;
    #1;
    check_val("t5_rx_pre", int'(Rx), Fwd ? 'h3C : 'h11);
    check_val("t5_ry_pre", int'(Ry), Fwd ? 'h3C : 'h11);
    step(1'b0, 1'b0, 1'b1, 0, 5, 5, 5, 'h3C, 1'b1);
    #1;
    RW = 1'b0;
    #1;
    check_val("t5_rx_post", int'(Rx), 'h3C);
    check_val("t5_ry_post", int'(Ry), 'h3C);

    // WMode=11 is a no-op even with RW=1.
    step(1'b0, 1'b0, 1'b1, 0, 1, 1, 1, 'h9A, 1'b1);
    step(1'b0, 1'b0, 1'b1, 3, 1, 1, 1, 'h00, 1'b1);
    check_val("t6_reg1", int'(Rx), 'h9A);
    check_val("t6_zw", int'(Zw), 0);
    idle_read(1, 1);

    // Random traffic, including writes and Clr while busy.
    for (int n = 0; n < 1500; n++) begin
      rst  = ($urandom_range(0, 199) == 0);
      clr  = ($urandom_range(0, 29) == 0);
      rw   = $urandom_range(0, 1) == 1;
      mode = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0:       data = 'h00;
        1:       data = 'hFF;
        2:       data = 'h01;
        default: data = $urandom_range(0, 255);
      endcase
      step(rst, clr, rw, mode, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), data, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
